// File: rtl/lifo_stack_pkg.sv
// Shared opcodes, FSM states and tile-top defaults for the lifo_stack engine.
package lifo_stack_pkg;

  localparam int LIFO_WIDTH_DEF = 8;
  localparam int LIFO_DEPTH_DEF = 16;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_DUP     = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } state_e;

endpackage

// File: rtl/lifo_stack_mem.sv
// Flop-array storage for lifo_stack: one write port, combinational top/peek reads.
// Peek read port exists only when LIFO_STACK_PEEK_EN is defined.
module lifo_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    top_addr_i,
  output logic [WIDTH-1:0] top_rdata_o
`ifdef LIFO_STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    peek_addr_i,
  output logic [WIDTH-1:0] peek_rdata_o
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign top_rdata_o = mem_q[top_addr_i];

`ifdef LIFO_STACK_PEEK_EN
  assign peek_rdata_o = mem_q[peek_addr_i];
`endif

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack engine: opcode command interface, multi-cycle CLEAR wipe, sticky error flags.
// Define LIFO_STACK_PEEK_EN to add peek_idx/peek_data ports and the DUP opcode.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter  int WIDTH = LIFO_WIDTH_DEF,
  parameter  int DEPTH = LIFO_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             done,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_illegal
`ifdef LIFO_STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data
`endif
);

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    idx_q, idx_d;
  logic             done_q, ovf_q, unf_q, ill_q;

  logic             accept;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] top_word;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign done      = done_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_illegal   = ill_q;
  assign idx_d     = idx_q + AW'(1);

  // Address wraps harmlessly when empty; top_data is masked to zero then.
  assign top_addr  = AW'(count_q - CW'(1));
  assign top_data  = empty ? '0 : top_word;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_CLR) begin
      mem_we   = 1'b1;
      mem_addr = idx_q;
    end else if (accept) begin
      case (cmd_op)
        OP_PUSH: begin
          mem_we    = !full;
          mem_addr  = AW'(count_q);
          mem_wdata = cmd_data;
        end
        OP_REPLACE: begin
          mem_we    = !empty;
          mem_addr  = top_addr;
          mem_wdata = cmd_data;
        end
`ifdef LIFO_STACK_PEEK_EN
        OP_DUP: begin
          mem_we    = !full && !empty;
          mem_addr  = AW'(count_q);
          mem_wdata = top_word;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            done_q <= 1'b1;
            case (cmd_op)
              OP_NOP: ;
              OP_PUSH: begin
                if (full) ovf_q <= 1'b1;
                else      count_q <= count_q + CW'(1);
              end
              OP_POP: begin
                if (empty) unf_q <= 1'b1;
                else       count_q <= count_q - CW'(1);
              end
              OP_REPLACE: begin
                if (empty) unf_q <= 1'b1;
              end
              OP_CLEAR: begin
                done_q  <= 1'b0;
                count_q <= '0;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
                ill_q   <= 1'b0;
                idx_q   <= '0;
                state_q <= ST_CLR;
              end
`ifdef LIFO_STACK_PEEK_EN
              OP_DUP: begin
                if (full)       ovf_q <= 1'b1;
                else if (empty) unf_q <= 1'b1;
                else            count_q <= count_q + CW'(1);
              end
`endif
              default: ill_q <= 1'b1;
            endcase
          end
        end
        ST_CLR: begin
          idx_q <= idx_d;
          // Last wipe: return to IDLE so done lands in the first ready cycle.
          if (idx_q == AW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LIFO_STACK_PEEK_EN
  logic [WIDTH-1:0] peek_word;
  logic [AW-1:0]    peek_addr;

  assign peek_addr = AW'(count_q - CW'(1) - CW'(peek_idx));
  assign peek_data = (CW'(peek_idx) < count_q) ? peek_word : '0;
`endif

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (mem_we),
    .waddr_i      (mem_addr),
    .wdata_i      (mem_wdata),
    .top_addr_i   (top_addr),
    .top_rdata_o  (top_word)
`ifdef LIFO_STACK_PEEK_EN
    ,
    .peek_addr_i  (peek_addr),
    .peek_rdata_o (peek_word)
`endif
  );

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack at WIDTH=8, DEPTH=4.
// Covers the LIFO_STACK_PEEK_EN build too when that macro is defined.
module tb_lifo_stack;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [W-1:0]  cmd_data = '0;
  logic [W-1:0]  top_data;
  logic [CW-1:0] count;
  logic          full, empty, done;
  logic          err_overflow, err_underflow, err_illegal;
`ifdef LIFO_STACK_PEEK_EN
  logic [AW-1:0] peek_idx = '0;
  logic [W-1:0]  peek_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lifo_stack #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .top_data      (top_data),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .done          (done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_illegal   (err_illegal)
`ifdef LIFO_STACK_PEEK_EN
    ,
    .peek_idx      (peek_idx),
    .peek_data     (peek_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command now, let one rising edge pass, sample 1ns later.
  task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] data);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [CW-1:0] c, input logic [W-1:0] t,
                              input logic dn, input logic ov, input logic un, input logic il);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".top"},   32'(top_data), 32'(t));
    chk({tag, ".done"},  32'(done), 32'(dn));
    chk({tag, ".ovf"},   32'(err_overflow), 32'(ov));
    chk({tag, ".unf"},   32'(err_underflow), 32'(un));
    chk({tag, ".ill"},   32'(err_illegal), 32'(il));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    expect_state("rst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full",  32'(full), 32'd0);
    chk("rst.ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back pushes
    step(1'b1, 3'd1, 8'h11); expect_state("push11", 3'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h22); expect_state("push22", 3'd2, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h33); expect_state("push33", 3'd3, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h44); expect_state("push44", 3'd4, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("push44.full", 32'(full), 32'd1);
    step(1'b1, 3'd1, 8'h55); expect_state("push55ovf", 3'd4, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd3, 8'hAA); expect_state("replAA", 3'd4, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);

    // Pop down to empty, then underflow
    step(1'b1, 3'd2, 8'h00); expect_state("pop1", 3'd3, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd2, 8'h00); expect_state("pop2", 3'd2, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd2, 8'h00); expect_state("pop3", 3'd1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd2, 8'h00); expect_state("pop4", 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pop4.empty", 32'(empty), 32'd1);
    step(1'b1, 3'd2, 8'h00); expect_state("pop5unf", 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 3'd3, 8'hBB); expect_state("replEmpty", 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 8'h00); expect_state("idle", 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

    // Illegal opcode sets its sticky flag
    step(1'b1, 3'd7, 8'h00); expect_state("op7", 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // CLEAR with flags set; a PUSH stays valid across the wipe
    step(1'b1, 3'd4, 8'h00);
    expect_state("clr.acc", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr.ready0", 32'(cmd_ready), 32'd0);
    step(1'b1, 3'd1, 8'h77);
    chk("clr.ready1", 32'(cmd_ready), 32'd0);
    chk("clr.done1",  32'(done), 32'd0);
    step(1'b1, 3'd1, 8'h77);
    chk("clr.ready2", 32'(cmd_ready), 32'd0);
    step(1'b1, 3'd1, 8'h77);
    chk("clr.ready3", 32'(cmd_ready), 32'd0);
    chk("clr.count3", 32'(count), 32'd0);
    step(1'b1, 3'd1, 8'h77);
    chk("clr.ready4", 32'(cmd_ready), 32'd1);
    chk("clr.done",   32'(done), 32'd1);
    chk("clr.count4", 32'(count), 32'd0);
    step(1'b1, 3'd1, 8'h77); expect_state("heldpush", 3'd1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);

    // NOP and illegal opcode leave the stack untouched
    step(1'b1, 3'd0, 8'hEE); expect_state("nop", 3'd1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 8'hEE); expect_state("op6", 3'd1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
`ifndef LIFO_STACK_PEEK_EN
    step(1'b1, 3'd4, 8'h00);
    repeat (4) step(1'b0, 3'd0, 8'h00);
    step(1'b1, 3'd5, 8'h00); expect_state("op5ill", 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 8'h5A);
`endif
    step(1'b0, 3'd0, 8'h00);

    // Asynchronous reset between edges with non-reset outputs
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("arst", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-CLEAR
    step(1'b1, 3'd1, 8'h3C);
    step(1'b1, 3'd4, 8'h00);
    step(1'b0, 3'd0, 8'h00);
    chk("midclr.busy", 32'(cmd_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midclr.ready", 32'(cmd_ready), 32'd1);
    expect_state("midclr", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 3'd1, 8'h9C); expect_state("postrst", 3'd1, 8'h9C, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 8'h00);

`ifdef LIFO_STACK_PEEK_EN
    step(1'b1, 3'd1, 8'h01);
    step(1'b1, 3'd1, 8'h02);
    step(1'b1, 3'd1, 8'h03);
    step(1'b0, 3'd0, 8'h00);
    peek_idx = 2'd0; #1; chk("peek0", 32'(peek_data), 32'h03);
    peek_idx = 2'd1; #1; chk("peek1", 32'(peek_data), 32'h02);
    peek_idx = 2'd2; #1; chk("peek2", 32'(peek_data), 32'h01);
    peek_idx = 2'd3; #1; chk("peek3", 32'(peek_data), 32'h00);
    step(1'b1, 3'd5, 8'hFF); expect_state("dup", 3'd4, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    peek_idx = 2'd3; #1; chk("peek3b", 32'(peek_data), 32'h01);
    step(1'b1, 3'd5, 8'hFF); expect_state("dupovf", 3'd4, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd4, 8'h00);
    repeat (4) step(1'b0, 3'd0, 8'h00);
    step(1'b1, 3'd5, 8'h00); expect_state("dupunf", 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO stack engine, the successor to the fixed 16x8 stack: configurable word width and depth, with an opcode command interface.
- Supports push, pop, replace-top and a multi-cycle clear.
- Reports occupancy, sticky error flags and a per-command completion pulse; the tile top maps these onto ui_in/uo_out/uio pins.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- CW, $clog2(DEPTH+1), count width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine can accept a command.
- cmd_op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 CLEAR, 5-7 illegal.
- cmd_data  input  WIDTH  write data for PUSH/REPLACE.
- top_data  output  WIDTH  current top-of-stack word; 0 when empty.
- count  output  CW  number of valid entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- done  output  1  one-cycle pulse per completed command.
- err_overflow  output  1  sticky: PUSH attempted while full.
- err_underflow  output  1  sticky: POP/REPLACE attempted while empty.
- err_illegal  output  1  sticky: opcode 5-7 accepted.

Behaviour:
- Reset (async on rst_n low): state IDLE, count=0, all entries=0, done=0, all error flags=0, cmd_ready=1 once released.
- FSM: IDLE, CLR.
- Handshake: a command is accepted on a rising edge with cmd_valid&&cmd_ready. cmd_ready = (state==IDLE). cmd_op/cmd_data are sampled only at acceptance.
- Storage: flop array mem[0..DEPTH-1]; the top entry is mem[count-1]. top_data = empty ? 0 : mem[count-1] (combinational from flops, so it reflects the new state the cycle after acceptance).
- PUSH, not full: mem[count]<=cmd_data, count+1.
- PUSH, full: no state change; err_overflow<=1.
- POP, not empty: count-1. The popped entry is not zeroed.
- POP, empty: no change; err_underflow<=1.
- REPLACE, not empty: mem[count-1]<=cmd_data, count unchanged. Legal when full.
- REPLACE, empty: no change; err_underflow<=1.
- NOP: no state change; done still pulses.
- Illegal opcode: no state change; err_illegal<=1.
- done timing for every op except CLEAR: done=1 for exactly one cycle, the cycle after acceptance. This includes erroring ops.
- CLEAR on acceptance: count<=0, all three error flags<=0, idx<=0, go to CLR.
- CLR state: each cycle mem[idx]<=0, idx+1. After writing DEPTH-1 go to IDLE and pulse done the following cycle. CLEAR occupies exactly DEPTH cycles of cmd_ready=0 and is the only way, besides reset, to clear the sticky flags.
- Back-to-back commands: one per cycle in IDLE; no bubble required.
- Reset mid-CLEAR: immediate return to the reset state; the partial wipe is irrelevant because reset zeroes the array.
- Width rules: count arithmetic is CW bits and never wraps (guarded by full/empty). The idx counter is $clog2(DEPTH) bits.

Optional Feature:
- Macro: LIFO_STACK_PEEK_EN.
- Defined: extra ports peek_idx (input, $clog2(DEPTH)) and peek_data (output, WIDTH).
  - peek_data = mem[count-1-peek_idx] when peek_idx<count, else 0. Purely combinational, no effect on state.
  - Adds opcode 5 DUP: push a copy of the top entry. It follows the full/empty error rules (overflow if full, underflow if empty), and 5 is then no longer illegal.
- Undefined: no peek ports; opcode 5 is illegal.

Decomposition:
- Shared package lifo_stack_pkg holds:
  - opcode localparams (OP_NOP..OP_DUP),
  - FSM state encoding (ST_IDLE, ST_CLR),
  - the WIDTH/DEPTH defaults used by the tile top.
- One sub-module is natural: lifo_stack_mem.
  - Flop array with async reset.
  - One write port (addr, data, we).
  - Combinational read ports for top and peek.
- The controller (FSM, count, flags, done) stays in lifo_stack.

Test Plan (WIDTH=8, DEPTH=4):
- Reset, then PUSH 0x11, 0x22, 0x33 back-to-back -> count=3, top_data=0x33, three done pulses, one cycle after each accept.
- Fill to 4 with PUSH 0x44, then PUSH 0x55 -> full=1, count stays 4, top_data=0x44, err_overflow=1, done pulses.
- REPLACE 0xAA while full -> top_data=0xAA, count=4. Then POP x4 -> top_data sequence 0x33, 0x22, 0x11, then 0 with empty=1. A 5th POP -> err_underflow=1.
- CLEAR with flags set -> cmd_ready=0 for 4 cycles, count=0 and flags=0 the cycle after accept, done pulses the cycle after the last wipe. A command held valid during CLR is not accepted until ready.
- Opcode 7 -> err_illegal=1, no count change. Assert rst_n low mid-CLEAR -> all outputs at reset values asynchronously, without waiting for a clock edge.
- With LIFO_STACK_PEEK_EN: push 0x01, 0x02, 0x03 -> peek_idx=0,1,2,3 gives 0x03, 0x02, 0x01, 0x00. DUP -> count=4, top_data=0x03.
